// File: rtl/hilo_acc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_acc_unit: HI/LO register pair with a multi-cycle multiply-accumulate  |
// | engine (MADDU/MADD/MSUBU/MSUB); HILO_BYPASS_EN enables next-value bypass.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hilo_acc_unit #(
    parameter int DW         = 32,
    parameter int ACC_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    input  logic          acc_start,
    input  logic [1:0]    acc_op,
    input  logic [DW-1:0] acc_a,
    input  logic [DW-1:0] acc_b,
    output logic          acc_busy,
    output logic          acc_done,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic [DW-1:0] hi_fwd_o,
    output logic [DW-1:0] lo_fwd_o
);

    localparam int              c_CW       = 4;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(ACC_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_ACC  = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [2*DW-1:0] r_prod;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic            r_done;

    logic [2*DW-1:0] w_ext_a;
    logic [2*DW-1:0] w_ext_b;
    logic [2*DW-1:0] w_prod_nxt;
    logic [2*DW-1:0] w_cur;
    logic [2*DW-1:0] w_acc;
    logic            w_in_acc;
    logic [DW-1:0]   w_hi_nxt;
    logic [DW-1:0]   w_lo_nxt;

    // op[0] selects signed extension, op[1] selects subtract; a truncated
    // 2*DW product of the extended operands is exact modulo 2^(2*DW).
    assign w_ext_a    = r_op[0] ? {{DW{r_a[DW-1]}}, r_a} : {{DW{1'b0}}, r_a};
    assign w_ext_b    = r_op[0] ? {{DW{r_b[DW-1]}}, r_b} : {{DW{1'b0}}, r_b};
    assign w_prod_nxt = w_ext_a * w_ext_b;

    assign w_cur    = {r_hi, r_lo};
    assign w_acc    = r_op[1] ? (w_cur - r_prod) : (w_cur + r_prod);
    assign w_in_acc = (r_state == c_ACC);

    // Direct writes take priority over the accumulate result per half.
    assign w_hi_nxt = we_hi ? hi_i : (w_in_acc ? w_acc[2*DW-1:DW] : r_hi);
    assign w_lo_nxt = we_lo ? lo_i : (w_in_acc ? w_acc[DW-1:0]    : r_lo);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
            r_done <= w_in_acc;
            case (r_state)
                c_IDLE: begin
                    if (acc_start) begin
                        r_op    <= acc_op;
                        r_a     <= acc_a;
                        r_b     <= acc_b;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= c_MUL;
                    end
                end
                c_MUL: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == c_CW'(1)) begin
                        r_state <= c_ACC;
                    end
                end
                c_ACC: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign acc_busy = (r_state != c_IDLE);
    assign acc_done = r_done;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

`ifdef HILO_BYPASS_EN
    assign hi_fwd_o = w_hi_nxt;
    assign lo_fwd_o = w_lo_nxt;
`else
    assign hi_fwd_o = r_hi;
    assign lo_fwd_o = r_lo;
`endif

endmodule
`default_nettype wire
